mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates a single-ported, 32-bit-wide program/data memory between the core's instruction-fetch port and its load/store port. The block issues at most one memory access per cycle and returns the read data one cycle later on the owning port. Data accesses have priority; a fetch starvation counter guarantees forward progress. A flush input discards an in-flight fetch response on a branch or jump redirect.

## Interface
- ADDR_W, 8, memory word-address width (depth 2^ADDR_W words)
- MAX_FETCH_WAIT, 2, consecutive cycles a pending fetch may lose before it is forced to win (1..15)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held stable until if_gnt
- if_addr  in  32  fetch byte address
- if_flush  in  1  discard the fetch response due next cycle
- if_gnt  out  1  fetch issued this cycle (combinational)
- if_valid  out  1  fetch data valid (registered)
- if_rdata  out  32  fetch data
- d_req  in  1  load/store request; held stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables (ignored for loads)
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, already lane-aligned
- d_gnt  out  1  data access issued this cycle (combinational)
- d_valid  out  1  load data valid / store acknowledge (registered)
- d_rdata  out  32  load data, full word
- mem_en  out  1  memory access strobe
- mem_we  out  4  per-byte write enables
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data
- mem_rdata  in  32  synchronous-read data, valid one cycle after mem_en

## Operation
- Word address = byte_addr[ADDR_W+1:2]; bits [1:0] and bits above ADDR_W+1 are ignored (wrap-around).
- Arbitration, per cycle: if d_req and not (if_req and wait_cnt == MAX_FETCH_WAIT) then data wins; else if if_req then fetch wins; else idle.
- wait_cnt (4 bits): increments when if_req and not if_gnt; clears on if_gnt or when if_req = 0; saturates at MAX_FETCH_WAIT.
- Winner drives mem_en = 1, mem_addr, mem_we = d_be for a data store, else 4'b0000; mem_wdata = d_wdata (don't-care for fetch).
- Owner register: NONE / IF / D, loaded every cycle with the winner; reset to NONE.
- Response cycle: owner IF gives if_valid = 1 unless if_flush is high in that cycle; owner D gives d_valid = 1. if_rdata and d_rdata both mirror mem_rdata; only the valid flag qualifies them.
- if_flush does not block a new fetch grant in the same cycle; it only suppresses the response of the previous grant.

## Timing
- Reset (rst = 0): owner = NONE, wait_cnt = 0, if_valid = d_valid = 0; if_gnt, d_gnt, mem_en, mem_we are 0 while rst = 0 regardless of requests. A response in flight at reset is dropped.
- Grant is combinational in cycle N; mem_rdata and the valid flag appear in cycle N+1. Back-to-back grants every cycle give one response per cycle.
- Store: d_valid pulses in N+1; memory contents change at the edge ending cycle N.
- Simultaneous if_req and d_req: data wins for up to MAX_FETCH_WAIT cycles, then fetch wins for exactly one cycle, and the counter clears.
- A request dropped before its grant is not remembered.

## Test plan
- Reset: hold rst = 0 with if_req = d_req = 1 -> all grants, valids, mem_en and mem_we = 0; release -> d_gnt = 1 in the first cycle.
- Fetch only: if_addr = 0x4, 0x8, 0xC on successive cycles with mem[1..3] preloaded -> if_gnt every cycle, if_valid in N+1 with if_rdata 0x00100093, 0x00500113, 0x01400193.
- Contention: constant if_req and d_req, MAX_FETCH_WAIT = 2 -> grant pattern D, D, IF, D, D, IF; wait_cnt peaks at 2.
- Store then load: sw to 0x13C with d_be = 4'b1111 and data 0xFFFFFB2E, then sb to 0x13D with d_be = 4'b0010 and d_wdata = 0x00001400, then a load of 0x13C -> d_rdata = 0xFFFF142E.
- Flush: fetch granted at N, if_flush = 1 in N+1 -> if_valid = 0 in N+1; a new fetch granted in N+1 returns if_valid = 1 in N+2.
- Wrap and reset mid-op: if_addr = 0x404 with ADDR_W = 8 -> mem_addr = 1; assert rst in the cycle after a grant -> no valid pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-ported 32-bit memory between instruction fetch
//            and load/store. Data accesses have priority, and a starvation
//            counter makes sure a waiting fetch eventually gets a slot. Read
//            data returns one cycle after the grant on the owning port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int MAX_FETCH_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    // load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    // memory side
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [3:0] MAX_WAIT = 4'(MAX_FETCH_WAIT);

    owner_t     owner_q, owner_d;
    logic [3:0] wait_q, wait_d;
    logic       fetch_forced;
    logic       d_win;
    logic       if_win;

    // Byte-offset bits and the bits above the word address are dropped so
    // that out-of-range addresses simply wrap around the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], if_addr[31:ADDR_W+2],
                                d_addr[1:0],  d_addr[31:ADDR_W+2]};

    // Arbitration, starvation counter next-state and memory request muxing.
    always_comb begin
        fetch_forced = if_req && (wait_q == MAX_WAIT);
        // Nothing is granted while reset is held, whatever the requests.
        d_win        = rst && d_req && !fetch_forced;
        if_win       = rst && if_req && !d_win;

        wait_d = wait_q;
        if (!if_req || if_win) begin
            wait_d = 4'd0;
        end else if (wait_q < MAX_WAIT) begin
            wait_d = wait_q + 4'd1;
        end

        owner_d = OWN_NONE;
        if (d_win) begin
            owner_d = OWN_D;
        end else if (if_win) begin
            owner_d = OWN_IF;
        end

        mem_en    = d_win || if_win;
        mem_addr  = d_win ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
        mem_we    = (d_win && d_we) ? d_be : 4'b0000;
        mem_wdata = d_wdata;
    end

    // Owner of the response slot and the fetch starvation counter; a reset
    // drops any response that was in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_NONE;
            wait_q  <= 4'd0;
        end else begin
            owner_q <= owner_d;
            wait_q  <= wait_d;
        end
    end

    // A flush in the response cycle hides the fetch data of the prior grant
    // without affecting a new fetch grant in the same cycle.
    always_comb begin
        if_gnt   = if_win;
        d_gnt    = d_win;
        if_valid = (owner_q == OWN_IF) && !if_flush;
        d_valid  = (owner_q == OWN_D);
        if_rdata = mem_rdata;
        d_rdata  = mem_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter with a response
//            scoreboard and a reference copy of memory contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 8;
    localparam int G_NONE = 0;
    localparam int G_IF   = 1;
    localparam int G_D    = 2;

    typedef struct packed {
        logic [1:0]  kind;   // 0 none, 1 fetch, 2 data
        logic [31:0] data;
        logic        chk;
    } resp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, if_flush, if_gnt, if_valid;
    logic [31:0]       if_addr, if_rdata;
    logic              d_req, d_we, d_gnt, d_valid;
    logic [3:0]        d_be;
    logic [31:0]       d_addr, d_wdata, d_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    logic [31:0] mem     [0:(1<<ADDR_W)-1];
    logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
    resp_t       sb_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .MAX_FETCH_WAIT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous-read, byte-writable memory attached to the arbiter.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, check the response due from the previous
    // grant, check this cycle's grant and queue its expected response.
    task automatic step(input logic r, input logic ifr, input logic [31:0] ifa,
                        input logic fl, input logic dr, input logic dwe,
                        input logic [3:0] dbe, input logic [31:0] da,
                        input logic [31:0] dwd, input int exp_g);
        resp_t             e;
        logic [ADDR_W-1:0] w;
        @(negedge clk);
        rst = r; if_req = ifr; if_addr = ifa; if_flush = fl;
        d_req = dr; d_we = dwe; d_be = dbe; d_addr = da; d_wdata = dwd;
        #1;
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        chk("if_valid", if_valid, r && (e.kind == 2'd1) && !fl);
        chk("d_valid",  d_valid,  r && (e.kind == 2'd2));
        if (r && (e.kind == 2'd1) && !fl) chk("if_rdata", if_rdata, e.data);
        if (r && (e.kind == 2'd2) && e.chk) chk("d_rdata", d_rdata, e.data);

        chk("if_gnt", if_gnt, exp_g == G_IF);
        chk("d_gnt",  d_gnt,  exp_g == G_D);
        chk("mem_en", mem_en, exp_g != G_NONE);
        if (exp_g == G_IF) begin
            w = ifa[ADDR_W+1:2];
            chk("if_mem_addr", mem_addr, w);
            chk("if_mem_we", mem_we, 4'b0000);
            sb_q.push_back('{2'd1, ref_mem[w], 1'b1});
        end else if (exp_g == G_D) begin
            w = da[ADDR_W+1:2];
            chk("d_mem_addr", mem_addr, w);
            chk("d_mem_we", mem_we, dwe ? dbe : 4'b0000);
            if (dwe) chk("d_mem_wdata", mem_wdata, dwd);
            sb_q.push_back('{2'd2, ref_mem[w], !dwe});
            if (dwe) begin
                for (int b = 0; b < 4; b++) begin
                    if (dbe[b]) ref_mem[w][8*b +: 8] = dwd[8*b +: 8];
                end
            end
        end else begin
            chk("idle_mem_we", mem_we, 4'b0000);
            sb_q.push_back('0);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = 32'hA500_0000 | i;
        ref_mem[1] = 32'h0010_0093;
        ref_mem[2] = 32'h0050_0113;
        ref_mem[3] = 32'h0140_0193;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = ref_mem[i];
        rst = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;

        // Reset held with both requests pending, then released.
        step(0, 1, 32'h4, 0, 1, 0, 4'h0, 32'h100, 0, G_NONE);
        step(0, 1, 32'h4, 0, 1, 0, 4'h0, 32'h100, 0, G_NONE);
        // Contention: D, D, IF, D, D, IF.
        step(1, 1, 32'h4, 0, 1, 0, 4'h0, 32'h100, 0, G_D);
        step(1, 1, 32'h4, 0, 1, 0, 4'h0, 32'h104, 0, G_D);
        step(1, 1, 32'h4, 0, 1, 0, 4'h0, 32'h108, 0, G_IF);
        step(1, 1, 32'h8, 0, 1, 0, 4'h0, 32'h108, 0, G_D);
        step(1, 1, 32'h8, 0, 1, 0, 4'h0, 32'h10C, 0, G_D);
        step(1, 1, 32'h8, 0, 1, 0, 4'h0, 32'h110, 0, G_IF);
        step(1, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0,   0, G_NONE);

        // Fetch only, back to back.
        step(1, 1, 32'h4, 0, 0, 0, 4'h0, 32'h0, 0, G_IF);
        step(1, 1, 32'h8, 0, 0, 0, 4'h0, 32'h0, 0, G_IF);
        step(1, 1, 32'hC, 0, 0, 0, 4'h0, 32'h0, 0, G_IF);
        step(1, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 0, G_NONE);
        chk("fetch_word3", if_rdata, 32'h0140_0193);

        // Word store, byte store, load back the merged word.
        step(1, 0, 32'h0, 0, 1, 1, 4'b1111, 32'h13C, 32'hFFFF_FB2E, G_D);
        step(1, 0, 32'h0, 0, 1, 1, 4'b0010, 32'h13D, 32'h0000_1400, G_D);
        step(1, 0, 32'h0, 0, 1, 0, 4'b0000, 32'h13C, 32'h0,         G_D);
        step(1, 0, 32'h0, 0, 0, 0, 4'h0,    32'h0,   32'h0,         G_NONE);
        chk("sb_merge", d_rdata, 32'hFFFF_142E);

        // Flush suppresses the older fetch response but not the new grant.
        step(1, 1, 32'h8, 0, 0, 0, 4'h0, 32'h0, 0, G_IF);
        step(1, 1, 32'hC, 1, 0, 0, 4'h0, 32'h0, 0, G_IF);
        step(1, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 0, G_NONE);

        // Address wrap: byte 0x404 maps to word 1.
        step(1, 1, 32'h404, 0, 0, 0, 4'h0, 32'h0, 0, G_IF);
        chk("wrap_addr", mem_addr, 8'd1);
        step(1, 0, 32'h0,   0, 0, 0, 4'h0, 32'h0, 0, G_NONE);

        // Reset in the cycle after a grant drops the response.
        step(1, 1, 32'h10, 0, 0, 0, 4'h0, 32'h0,   0, G_IF);
        step(0, 1, 32'h10, 0, 1, 0, 4'h0, 32'h200, 0, G_NONE);
        step(1, 1, 32'h10, 0, 1, 0, 4'h0, 32'h200, 0, G_D);
        step(1, 0, 32'h0,  0, 0, 0, 4'h0, 32'h0,   0, G_NONE);
        step(1, 0, 32'h0,  0, 0, 0, 4'h0, 32'h0,   0, G_NONE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
